uart_rx: RTL and testbench
==========================

# uart_rx

16x-oversampling UART receiver. Consumes the one-cycle `tick` strobe from the UART baud-rate generator (16 ticks per bit period), samples the asynchronous `rx` line at bit centres, and delivers each received character as a parallel word with a one-cycle `rx_done` strobe. It is the receive-side counterpart of the UART transmitter in the serial subsystem.

## Interface

- DATA_BITS, 8, data bits per frame (5–9), LSB first
- STOP_TICKS, 16, oversampling ticks spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- tick  input  1  16x baud strobe, one clk wide, from the baud-rate generator
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  last received character, held until the next rx_done
- rx_done  output  1  one-cycle strobe: rx_data/frame_err/parity_err are valid
- frame_err  output  1  stop bit sampled low for the frame flagged by rx_done
- parity_err  output  1  parity mismatch for the frame flagged by rx_done (0 when parity is compiled out)
- busy  output  1  high while state ≠ IDLE

## Operation

- `rx` passes through a 2-FF synchronizer; both flops reset to 1. All FSM decisions use the synchronized value `rx_s`.
- Counters: `s` (tick counter, 4 bits minimum, wide enough for STOP_TICKS-1) and `n` (bit counter, $clog2(DATA_BITS) bits). Counters advance only on cycles where `tick`=1.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
  - IDLE: on `rx_s`=0 (no tick required) -> START, s=0.
  - START: on tick, if s==7: `rx_s`=0 -> DATA, s=0, n=0; `rx_s`=1 -> IDLE (glitch rejected, no strobe). Else s++.
  - DATA: on tick, if s==15: shift register `b <= {rx_s, b[DATA_BITS-1:1]}`, s=0; if n==DATA_BITS-1 -> PARITY (or STOP), else n++. Else s++.
  - PARITY: on tick, if s==15: capture parity bit, s=0 -> STOP. Else s++.
  - STOP: on tick, if s==STOP_TICKS-1: -> IDLE; register rx_data<=b, frame_err<=~rx_s, parity_err<=computed mismatch, rx_done<=1. Else s++.
- rx_done is high for exactly one clk; frame_err/parity_err hold until the next rx_done.
- A frame with frame_err is still delivered (rx_done=1); data is not suppressed.
- Reset at any time: state IDLE, s=n=0, b=0, all outputs return to reset values; a partially received frame is discarded without a strobe.

## Timing

- Reset values: rx_data=0, rx_done=0, frame_err=0, parity_err=0, busy=0.
- All outputs are registered.
- Start detection latency: 2 clk (synchronizer) + 1 clk to enter START.
- rx_done rises in the clk following the tick on which STOP's last count is reached; i.e. ~(1/2 + DATA_BITS + P + STOP_TICKS/16) bit periods after the start edge (P = 1 with parity, else 0).
- The FSM returns to IDLE in the same cycle rx_done rises, so a start bit directly following the stop bit (back-to-back frames) is detected with no lost frame.
- `rx` changes inside a bit period are ignored except at the sample point (s==7 for start, s==15 thereafter).

## Configuration

- `UART_RX_PARITY_EN` defined: PARITY state present; one parity bit follows the data bits; even parity (data bits XOR parity bit must be 0); parity_err reports mismatch.
- Not defined: no PARITY state, DATA -> STOP directly, parity_err tied to 0.

## Test plan

Bench drives `tick` every 4 clk; one bit = 64 clk.
- Frame 0xA5 (8N1, valid stop) -> one rx_done pulse, rx_data=0xA5, frame_err=0, busy low after the strobe.
- Low pulse of 3 ticks on idle line -> START aborts at s==7, returns to IDLE, no rx_done, rx_data unchanged.
- Frame 0x3C with stop bit driven 0 -> rx_done=1, rx_data=0x3C, frame_err=1; next valid frame 0x55 clears frame_err to 0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_done pulses, rx_data 0x00 then 0xFF, no errors.
- reset_n pulsed low after 4 data bits of 0x81, then frame 0x7E -> no strobe for 0x81; outputs reset; 0x7E received correctly.
- With UART_RX_PARITY_EN: 0x01 with parity bit 1 -> parity_err=0; 0x01 with parity bit 0 -> parity_err=1, rx_data=0x01.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x-oversampling UART receiver; define UART_RX_PARITY_EN for an even-parity bit.
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_TICKS = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_done,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int S_W = ($clog2(STOP_TICKS) > 4) ? $clog2(STOP_TICKS) : 4;
   localparam int N_W = $clog2(DATA_BITS);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state;
   logic [S_W-1:0]       s;
   logic [N_W-1:0]       n;
   logic [DATA_BITS-1:0] b;
   logic                 rx_meta;
   logic                 rx_s;
`ifdef UART_RX_PARITY_EN
   logic                 p;
`endif

   // Line idles high, so the synchronizer resets to 1 to avoid a false start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         s          <= '0;
         n          <= '0;
         b          <= '0;
         rx_data    <= '0;
         rx_done    <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         p          <= 1'b0;
`endif
      end else begin
         rx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  state <= START;
                  s     <= '0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (s == S_W'(7)) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s     <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (s == S_W'(15)) begin
                     b <= {rx_s, b[DATA_BITS-1:1]};
                     s <= '0;
                     if (n == N_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (tick) begin
                  if (s == S_W'(15)) begin
                     p     <= rx_s;
                     s     <= '0;
                     state <= STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  if (s == S_W'(STOP_TICKS - 1)) begin
                     state     <= IDLE;
                     s         <= '0;
                     busy      <= 1'b0;
                     rx_data   <= b;
                     frame_err <= ~rx_s;
                     rx_done   <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err <= ^{b, p};
`else
                     parity_err <= 1'b0;
`endif
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (8 data bits, 1 stop bit).
module tb_uart_rx;

   logic       clk;
   logic       reset_n;
   logic       tick;
   logic       rx;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       frame_err;
   logic       parity_err;
   logic       busy;

   int total = 0;
   int bad   = 0;
   int tcnt  = 0;

   int         done_cnt = 0;
   logic [7:0] got_data;
   logic       got_fe;
   logic       got_pe;
   logic [7:0] dq[$];

   uart_rx #(.DATA_BITS(8), .STOP_TICKS(16)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .tick(tick),
      .rx(rx),
      .rx_data(rx_data),
      .rx_done(rx_done),
      .frame_err(frame_err),
      .parity_err(parity_err),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One tick every 4 clk: one bit period is 64 clk.
   always @(negedge clk) begin
      tcnt = (tcnt == 3) ? 0 : tcnt + 1;
      tick = (tcnt == 0);
   end

   always @(negedge clk) begin
      if (rx_done) begin
         done_cnt = done_cnt + 1;
         got_data = rx_data;
         got_fe   = frame_err;
         got_pe   = parity_err;
         dq.push_back(rx_data);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total = total + 1;
      if (got !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Start, 8 data bits LSB first, optional even parity (flip corrupts it), stop bit.
   task automatic send_frame(input logic [7:0] d, input logic par_flip,
                             input logic stop_val, input int stop_len);
      rx = 1'b0;
      wait_clk(64);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         wait_clk(64);
      end
`ifdef UART_RX_PARITY_EN
      rx = (^d) ^ par_flip;
      wait_clk(64);
`endif
      rx = stop_val;
      wait_clk(stop_len);
      rx = 1'b1;
   endtask

   initial begin
      int base;
      rx      = 1'b1;
      tick    = 1'b0;
      reset_n = 1'b0;
      wait_clk(5);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_rx_done", rx_done, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_parity_err", parity_err, 0);
      check("reset_busy", busy, 0);
      reset_n = 1'b1;
      wait_clk(20);

      send_frame(8'hA5, 1'b0, 1'b1, 64);
      check("a5_count", done_cnt, 1);
      check("a5_data", got_data, 8'hA5);
      check("a5_frame_err", got_fe, 0);
      check("a5_parity_err", got_pe, 0);
      check("a5_busy_after", busy, 0);
      wait_clk(64);

      // 3-tick low glitch: rejected at the start-bit centre.
      rx = 1'b0;
      wait_clk(12);
      rx = 1'b1;
      wait_clk(128);
      check("glitch_count", done_cnt, 1);
      check("glitch_data", rx_data, 8'hA5);
      check("glitch_busy", busy, 0);

      // Stop bit low past its sample point, then idle long enough to reject the tail.
      send_frame(8'h3C, 1'b0, 1'b0, 40);
      wait_clk(2);
      check("3c_count", done_cnt, 2);
      check("3c_data", got_data, 8'h3C);
      check("3c_frame_err", got_fe, 1);
      wait_clk(160);
      check("3c_tail_count", done_cnt, 2);

      send_frame(8'h55, 1'b0, 1'b1, 64);
      check("55_count", done_cnt, 3);
      check("55_data", got_data, 8'h55);
      check("55_frame_err", got_fe, 0);
      wait_clk(64);

      base = dq.size();
      send_frame(8'h00, 1'b0, 1'b1, 64);
      send_frame(8'hFF, 1'b0, 1'b1, 64);
      check("b2b_count", done_cnt, 5);
      check("b2b_first", (dq.size() > base) ? dq[base] : 8'hxx, 8'h00);
      check("b2b_second", (dq.size() > base + 1) ? dq[base + 1] : 8'hxx, 8'hFF);
      check("b2b_frame_err", got_fe, 0);
      check("b2b_parity_err", got_pe, 0);
      wait_clk(64);

      // Reset mid-frame after four data bits of 0x81.
      rx = 1'b0;
      wait_clk(64);
      for (int i = 0; i < 4; i++) begin
         rx = (i == 0);
         wait_clk(64);
      end
      check("mid_busy", busy, 1);
      reset_n = 1'b0;
      rx      = 1'b1;
      wait_clk(3);
      check("rst_rx_data", rx_data, 8'h00);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      reset_n = 1'b1;
      wait_clk(640);
      check("rst_no_strobe", done_cnt, 5);

      send_frame(8'h7E, 1'b0, 1'b1, 64);
      check("7e_count", done_cnt, 6);
      check("7e_data", got_data, 8'h7E);
      check("7e_frame_err", got_fe, 0);
      wait_clk(64);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h01, 1'b0, 1'b1, 64);
      check("par_ok_count", done_cnt, 7);
      check("par_ok_err", got_pe, 0);
      wait_clk(64);
      send_frame(8'h01, 1'b1, 1'b1, 64);
      check("par_bad_count", done_cnt, 8);
      check("par_bad_err", got_pe, 1);
      check("par_bad_data", got_data, 8'h01);
      wait_clk(64);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
